// File: rtl/carry_propagation_packer.sv
// Carry propagation packer: resolves carries from the arithmetic encoder's 9-bit
// chunks over one held byte plus a run of 0xFF bytes, and emits final bitstream
// bytes over a valid/ready handshake. A flush drains the held state at end of frame.
module carry_propagation_packer #(
  parameter int unsigned GENERAL_RUN_WIDTH = 16
) (
  input  logic       general_clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [8:0] in_chunk,
  output logic       in_ready,
  input  logic       flush_req,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last,
  input  logic       out_ready,
  output logic       flush_done,
  output logic       carry_err,
  output logic       run_ovf
);

  localparam int unsigned RW = GENERAL_RUN_WIDTH;
  localparam logic [RW-1:0] RunMax  = '1;
  localparam logic [RW-1:0] RunZero = '0;
  localparam logic [RW-1:0] RunOne  = RW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StEmitHead,
    StEmitRun,
    StFlushHead
  } state_e;

  state_e        state_q, state_d;

  // Held byte awaiting a possible carry, and the count of 0xFF bytes behind it.
  logic          pend_q, pend_d;
  logic [7:0]    hold_q, hold_d;
  logic [RW-1:0] run_q, run_d;

  // Emission registers: one head byte followed by e_cnt copies of the fill byte.
  logic [7:0]    e_head_q, e_head_d;
  logic [7:0]    e_fill_q, e_fill_d;
  logic [RW-1:0] e_cnt_q, e_cnt_d;
  logic          e_last_q, e_last_d;

  logic          flush_done_q, flush_done_d;
  logic          carry_err_q, carry_err_d;
  logic          run_ovf_q, run_ovf_d;

  logic          chunk_carry;
  logic [7:0]    chunk_byte;

  assign chunk_carry = in_chunk[8];
  assign chunk_byte  = in_chunk[7:0];

  // State registers; synchronous reset drops any in-flight emission.
  always_ff @(posedge general_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_q       <= 1'b0;
      hold_q       <= 8'h00;
      run_q        <= RunZero;
      e_head_q     <= 8'h00;
      e_fill_q     <= 8'h00;
      e_cnt_q      <= RunZero;
      e_last_q     <= 1'b0;
      flush_done_q <= 1'b0;
      carry_err_q  <= 1'b0;
      run_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      run_q        <= run_d;
      e_head_q     <= e_head_d;
      e_fill_q     <= e_fill_d;
      e_cnt_q      <= e_cnt_d;
      e_last_q     <= e_last_d;
      flush_done_q <= flush_done_d;
      carry_err_q  <= carry_err_d;
      run_ovf_q    <= run_ovf_d;
    end
  end

  // Next-state: chunk intake and flush in idle, byte sequencing while emitting.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    hold_d       = hold_q;
    run_d        = run_q;
    e_head_d     = e_head_q;
    e_fill_d     = e_fill_q;
    e_cnt_d      = e_cnt_q;
    e_last_d     = e_last_q;
    flush_done_d = 1'b0;
    carry_err_d  = carry_err_q;
    run_ovf_d    = run_ovf_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!pend_q) begin
            // A carry with nothing held has nowhere to go.
            if (chunk_carry) begin
              carry_err_d = 1'b1;
            end
            hold_d = chunk_byte;
            pend_d = 1'b1;
            run_d  = RunZero;
          end else if (chunk_carry) begin
            // Carry ripples through the held byte; the 0xFF run wraps to 0x00.
            if (hold_q == 8'hFF) begin
              carry_err_d = 1'b1;
            end
            e_head_d = hold_q + 8'd1;
            e_fill_d = 8'h00;
            e_cnt_d  = run_q;
            e_last_d = 1'b0;
            hold_d   = chunk_byte;
            run_d    = RunZero;
            state_d  = StEmitHead;
          end else if (chunk_byte == 8'hFF) begin
            // A 0xFF may still absorb a future carry, so only count it.
            if (run_q == RunMax) begin
              run_ovf_d = 1'b1;
            end else begin
              run_d = run_q + RunOne;
            end
          end else begin
            // A non-0xFF byte settles everything ahead of it.
            e_head_d = hold_q;
            e_fill_d = 8'hFF;
            e_cnt_d  = run_q;
            e_last_d = 1'b0;
            hold_d   = chunk_byte;
            run_d    = RunZero;
            state_d  = StEmitHead;
          end
        end else if (flush_req) begin
          if (pend_q) begin
            e_head_d = hold_q;
            e_fill_d = 8'hFF;
            e_cnt_d  = run_q;
            e_last_d = 1'b1;
            state_d  = StFlushHead;
          end else begin
            flush_done_d = 1'b1;
          end
          pend_d = 1'b0;
          run_d  = RunZero;
        end
      end

      StEmitHead, StFlushHead: begin
        if (out_ready) begin
          if (e_cnt_q == RunZero) begin
            state_d      = StIdle;
            flush_done_d = e_last_q;
          end else begin
            state_d = StEmitRun;
          end
        end
      end

      StEmitRun: begin
        if (out_ready) begin
          e_cnt_d = e_cnt_q - RunOne;
          if (e_cnt_q == RunOne) begin
            state_d      = StIdle;
            flush_done_d = e_last_q;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs come only from registered state, so there is no input-to-output path.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
      end
      StEmitHead, StFlushHead: begin
        out_valid = 1'b1;
        out_byte  = e_head_q;
        out_last  = e_last_q && (e_cnt_q == RunZero);
      end
      StEmitRun: begin
        out_valid = 1'b1;
        out_byte  = e_fill_q;
        out_last  = e_last_q && (e_cnt_q == RunOne);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign flush_done = flush_done_q;
  assign carry_err  = carry_err_q;
  assign run_ovf    = run_ovf_q;

endmodule

// File: tb/tb_carry_propagation_packer.sv
// Bench for carry_propagation_packer: a byte-queue model of carry resolution
// predicts every emitted byte; literal byte lists pin each scenario.
module tb_carry_propagation_packer;

  logic       general_clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [8:0] in_chunk;
  logic       in_ready;
  logic       flush_req;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_ready;
  logic       flush_done;
  logic       carry_err;
  logic       run_ovf;

  carry_propagation_packer #(.GENERAL_RUN_WIDTH(16)) dut (
    .general_clk(general_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_chunk   (in_chunk),
    .in_ready   (in_ready),
    .flush_req  (flush_req),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .flush_done (flush_done),
    .carry_err  (carry_err),
    .run_ovf    (run_ovf)
  );

  always #5 general_clk = ~general_clk;

  int n_total = 0;
  int n_pass  = 0;

  // Entries are {last, byte}.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [8:0] lit_q[$];

  // Model state: held byte, pending flag, count of deferred 0xFF bytes, sticky flags.
  bit m_pend;
  int m_h;
  int m_r;
  bit m_err;
  bit m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: condition not met (got none, want event)", name);
  endtask

  task automatic model_reset();
    m_pend = 0; m_h = 0; m_r = 0; m_err = 0; m_ovf = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  // Settle the held byte (plus optional carry) and its 0xFF run into the output stream.
  task automatic model_settle(input bit carry, input bit last);
    int head;
    int fill;
    head = carry ? (m_h + 1) % 256 : m_h;
    fill = carry ? 0 : 255;
    exp_q.push_back({last && (m_r == 0), 8'(head)});
    for (int i = 0; i < m_r; i++) exp_q.push_back({last && (i == m_r - 1), 8'(fill)});
  endtask

  task automatic model_chunk(input logic [8:0] ch);
    bit c;
    int b;
    c = ch[8];
    b = int'(ch[7:0]);
    if (!m_pend) begin
      if (c) m_err = 1;
      m_h = b; m_pend = 1; m_r = 0;
    end else if (c) begin
      if (m_h == 255) m_err = 1;
      model_settle(1'b1, 1'b0);
      m_h = b; m_r = 0;
    end else if (b == 255) begin
      if (m_r == 65535) m_ovf = 1;
      else m_r++;
    end else begin
      model_settle(1'b0, 1'b0);
      m_h = b; m_r = 0;
    end
  endtask

  task automatic model_flush();
    if (m_pend) model_settle(1'b0, 1'b1);
    m_pend = 0; m_r = 0;
  endtask

  // Compare process: every handshaken byte against the model, and hold stability.
  initial begin
    bit         stall_prev;
    logic [7:0] prev_byte;
    logic       prev_last;
    logic [8:0] e;
    stall_prev = 0;
    prev_byte  = 8'h00;
    prev_last  = 1'b0;
    forever begin
      @(negedge general_clk);
      if (reset) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_byte", int'(out_byte), int'(prev_byte));
          check("hold_last", int'(out_last), int'(prev_last));
        end
        if (out_valid && out_ready) begin
          got_q.push_back({out_last, out_byte});
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_byte: got 0x%0h, want no byte", out_byte);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", int'(out_byte), int'(e[7:0]));
            check("out_last", int'(out_last), int'(e[8]));
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_byte  = out_byte;
        prev_last  = out_last;
      end
    end
  end

  // Drive one chunk until accepted; returns one step after the accepting edge.
  task automatic send(input logic [8:0] ch);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_chunk = ch;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge general_clk);
      if (in_ready) begin
        model_chunk(ch);
        done = 1;
      end
      @(posedge general_clk); #1;
    end
    in_valid = 1'b0;
    if (!done) fail("send_timeout");
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge general_clk);
      if (exp_q.size() == 0 && in_ready) done = 1;
    end
    @(posedge general_clk); #1;
    if (!done) fail("drain_timeout");
  endtask

  task automatic do_flush();
    bit done;
    done = 0;
    flush_req = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge general_clk);
      if (in_ready) begin
        model_flush();
        done = 1;
      end
      @(posedge general_clk); #1;
    end
    flush_req = 1'b0;
    if (!done) fail("flush_accept_timeout");
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge general_clk);
      if (flush_done) begin
        done = 1;
        check("flush_drained", exp_q.size(), 0);
      end
    end
    if (!done) begin
      fail("flush_done_timeout");
    end else begin
      @(negedge general_clk);
      check("flush_done_pulse", int'(flush_done), 0);
    end
    @(posedge general_clk); #1;
  endtask

  // Compare the handshaken bytes against a hand-written literal list, then clear.
  task automatic check_got(input string name);
    check({name, "_count"}, got_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
      check({name, "_lit"}, int'(got_q[i]), int'(lit_q[i]));
    got_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge general_clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    in_chunk  = 9'h000;
    flush_req = 1'b0;
    out_ready = 1'b1;
    @(posedge general_clk); #1;
    do_reset();

    // 1: reset state, then empty flush.
    @(negedge general_clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_carry_err", int'(carry_err), 0);
    check("rst_run_ovf", int'(run_ovf), 0);
    check("rst_out_byte", int'(out_byte), 0);
    check("rst_flush_done", int'(flush_done), 0);
    @(posedge general_clk); #1;
    do_flush();
    lit_q.delete();
    check_got("s1_flush");

    // 2: plain bytes with one-cycle latency.
    send(9'h012);
    send(9'h034);
    @(negedge general_clk);
    check("s2_latency_valid", int'(out_valid), 1);
    check("s2_latency_byte", int'(out_byte), 'h12);
    @(posedge general_clk); #1;
    wait_drain();
    lit_q = {9'h012};
    check_got("s2");
    do_flush();
    lit_q = {9'h134};
    check_got("s2_flush");

    // 3: carry through a 0xFF run.
    send(9'h0AB); send(9'h0FF); send(9'h0FF); send(9'h105);
    wait_drain();
    lit_q = {9'h0AC, 9'h000, 9'h000};
    check_got("s3");
    do_flush();
    lit_q = {9'h105};
    check_got("s3_flush");

    // 4: run settled without carry.
    send(9'h0AB); send(9'h0FF); send(9'h0FF); send(9'h010);
    wait_drain();
    lit_q = {9'h0AB, 9'h0FF, 9'h0FF};
    check_got("s4");
    @(negedge general_clk);
    check("s4_carry_err", int'(carry_err), 0);
    @(posedge general_clk); #1;
    do_flush();
    lit_q = {9'h110};
    check_got("s4_flush");

    // 5: scenario 3 with a 3-cycle stall on the second byte.
    out_ready = 1'b0;
    send(9'h0AB); send(9'h0FF); send(9'h0FF); send(9'h105);
    @(posedge general_clk); #1;
    out_ready = 1'b1;
    @(posedge general_clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge general_clk);
      check("s5_stall_byte", int'(out_byte), 'h00);
      check("s5_stall_valid", int'(out_valid), 1);
      check("s5_stall_in_ready", int'(in_ready), 0);
    end
    @(posedge general_clk); #1;
    out_ready = 1'b1;
    wait_drain();
    lit_q = {9'h0AC, 9'h000, 9'h000};
    check_got("s5");
    do_flush();
    lit_q = {9'h105};
    check_got("s5_flush");

    // Reset mid-emission drops everything, including the held byte.
    out_ready = 1'b0;
    send(9'h0AB); send(9'h0FF); send(9'h0FF); send(9'h0CD);
    @(posedge general_clk); #1;
    reset = 1'b1;
    @(posedge general_clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge general_clk);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(posedge general_clk); #1;
    out_ready = 1'b1;
    do_flush();
    lit_q.delete();
    check_got("mid_rst_flush");

    // 6: carry errors are sticky; carry into held 0xFF wraps to 0x00.
    do_reset();
    send(9'h105);
    @(negedge general_clk);
    check("s6_carry_err_first", int'(carry_err), 1);
    @(posedge general_clk); #1;
    send(9'h1FF);
    send(9'h100);
    wait_drain();
    lit_q = {9'h006, 9'h000};
    check_got("s6");
    @(negedge general_clk);
    check("s6_carry_err_sticky", int'(carry_err), 1);
    check("s6_carry_err_model", int'(carry_err), int'(m_err));
    check("s6_run_ovf", int'(run_ovf), int'(m_ovf));
    @(posedge general_clk); #1;
    do_flush();
    lit_q = {9'h100};
    check_got("s6_flush");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
